bbs_seed_checker: RTL and testbench
===================================

// Module: bbs_seed_checker
// PURPOSE
//  Parametrised seed validator for the BBS generator. Accepts a (seed, m) pair over a
//  valid/ready handshake and runs range and parity checks. It then runs a built-in
//  iterative binary GCD and returns a pass/fail verdict, a status code and gcd(seed, m).
//  Sits between seed loading and the BBS core; the core is only seeded when seed_valid=1.
// PARAMETERS
//  W        16   operand width in bits (seed, m, gcd_out); legal range 4..64
// PORTS
//  clk         in   1   single clock; all state updates on its rising edge
//  reset       in   1   asynchronous, active-low reset (0 = reset)
//  in_valid    in   1   request: seed/m valid
//  in_ready    out  1   checker can accept a request
//  seed        in   W   candidate seed x0
//  m           in   W   BBS modulus (p*q)
//  res_valid   out  1   result valid; held until accepted
//  res_ready   in   1   consumer accepts result
//  seed_valid  out  1   1 = seed usable (status==OK)
//  status      out  2   0 OK, 1 SEED_RANGE, 2 M_EVEN, 3 NOT_COPRIME
//  gcd_out     out  W   gcd(seed,m) if GCD ran; otherwise 0
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; in_ready=1, res_valid=0, seed_valid=0,
//  status=0, gcd_out=0, and all internal registers are cleared.
//  FSM IDLE -> CHECK -> GCD -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready, latch seed->b and m->a, then go to CHECK.
//  in_ready=0 in every other state.
//  CHECK (1 cycle), checks in priority order:
//   - seed<2 or seed>=m -> status=SEED_RANGE.
//   - else m[0]==0 -> status=M_EVEN.
//   - On either failure: gcd_out=0, go to DONE.
//   - Otherwise go to GCD.
//  GCD: one step per cycle on a,b. m is odd, so no common power of 2 is tracked.
//   - if a==0 or b==0: gcd_out=a|b, go to DONE.
//   - else if a even: a=a>>1.
//   - else if b even: b=b>>1.
//   - else if a>=b: a=(a-b)>>1.
//   - else: b=(b-a)>>1.
//   - Subtraction is W bits wide with no overflow (the larger operand is minuend).
//   - Worst case is 2W+1 GCD cycles. Total latency from accept to res_valid <= 2W+3.
//   - Exit: gcd_out==1 -> status=OK; otherwise status=NOT_COPRIME.
//  DONE: res_valid=1; seed_valid=(status==OK).
//   - res_valid, seed_valid, status and gcd_out stay stable while res_ready=0.
//   - On res_valid&&res_ready: res_valid=0, go to IDLE, in_ready=1 next cycle.
//   - status and gcd_out keep their last values until the next result.
//  A new request is never accepted in the same cycle a result is consumed.
//  Minimum request spacing is therefore 1 idle cycle.
//  in_valid while busy is ignored; the requester must hold it until in_ready.
//  Reset asserted mid-GCD or mid-DONE aborts immediately to reset values; no result is produced.
// CONFIGURATION
//  SEED_CHECK_STATS_EN defined:
//   - Adds output port cycles [15:0]: count of GCD-state cycles for the current result.
//   - Cleared on accept. Saturates at 16'hFFFF. Valid with res_valid. Reset value 0.
//  Not defined: port is absent and no counter logic is built. Functional behaviour is otherwise identical.
// TESTING
//  1 seed=3, m=253 -> res_valid, seed_valid=1, status=0, gcd_out=1.
//  2 seed=3, m=6 -> seed_valid=0, status=2 (M_EVEN), gcd_out=0, latency 2 cycles.
//  3 Range checks:
//    - seed=0, m=253 -> status=1.
//    - seed=253, m=253 -> status=1.
//    - seed=1, m=253 -> status=1.
//  4 seed=11, m=253 -> seed_valid=0, status=3, gcd_out=11.
//    W=32: seed=65537, m=32'hFFFFFFFB -> status=0, gcd_out=1, latency <= 67 cycles.
//  5 res_ready=0 for 10 cycles after res_valid -> outputs stable, in_ready=0.
//    Then accept -> in_ready=1 next cycle, and a back-to-back request is accepted.
//  6 Assert reset during GCD -> all outputs at reset values asynchronously.
//    Then a new request (seed=3, m=253) completes correctly.
//    With SEED_CHECK_STATS_EN: cycles is nonzero and <= 2W+1.

Source files
------------

// File: rtl/bbs_seed_checker.sv
// Seed validator for the BBS generator: range/parity checks plus binary GCD.
// Optional SEED_CHECK_STATS_EN adds a GCD cycle counter output.
module bbs_seed_checker #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] seed,
    input  logic [W-1:0] m,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         seed_valid,
    output logic [1:0]   status,
    output logic [W-1:0] gcd_out
`ifdef SEED_CHECK_STATS_EN
    ,
    output logic [15:0]  cycles
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] GCD   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_RANGE  = 2'd1;
    localparam logic [1:0] ST_M_EVEN = 2'd2;
    localparam logic [1:0] ST_NC     = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [1:0]   status_q, status_d;
    logic [W-1:0] gcd_q, gcd_d;
    logic [W-1:0] a_or_b;

    assign a_or_b = a_q | b_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        status_d = status_q;
        gcd_d    = gcd_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = m;
                    b_d     = seed;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (b_q < W'(2) || b_q >= a_q) begin
                    status_d = ST_RANGE;
                    gcd_d    = '0;
                    state_d  = DONE;
                end else if (!a_q[0]) begin
                    status_d = ST_M_EVEN;
                    gcd_d    = '0;
                    state_d  = DONE;
                end else begin
                    state_d = GCD;
                end
            end
            GCD: begin
                // m is odd, so no shared factor of two needs tracking
                if (a_q == '0 || b_q == '0) begin
                    gcd_d    = a_or_b;
                    status_d = (a_or_b == W'(1)) ? ST_OK : ST_NC;
                    state_d  = DONE;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            status_q <= ST_OK;
            gcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            status_q <= status_d;
            gcd_q    <= gcd_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign res_valid  = (state_q == DONE);
    assign seed_valid = (state_q == DONE) && (status_q == ST_OK);
    assign status     = status_q;
    assign gcd_out    = gcd_q;

`ifdef SEED_CHECK_STATS_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && in_valid) begin
            cyc_d = '0;
        end else if (state_q == GCD && cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_bbs_seed_checker.sv
// Scoreboard bench for bbs_seed_checker: Euclid reference model,
// latency bounds, backpressure, back-to-back and mid-GCD reset.
module tb_bbs_seed_checker;

    localparam int W = 16;

    typedef struct {
        logic [1:0]   st;
        logic [W-1:0] g;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] seed = '0;
    logic [W-1:0] m = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         seed_valid;
    logic [1:0]   status;
    logic [W-1:0] gcd_out;
`ifdef SEED_CHECK_STATS_EN
    logic [15:0]  cycles;
`endif

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];

    bbs_seed_checker #(.W(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .seed(seed),
        .m(m),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .seed_valid(seed_valid),
        .status(status),
        .gcd_out(gcd_out)
`ifdef SEED_CHECK_STATS_EN
        ,
        .cycles(cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] mm);
        exp_t e;
        logic [W-1:0] x, y, t;
        if (s < 2 || s >= mm) begin
            e.st = 2'd1;
            e.g  = '0;
        end else if (mm[0] == 1'b0) begin
            e.st = 2'd2;
            e.g  = '0;
        end else begin
            x = mm;
            y = s;
            while (y != 0) begin
                t = x % y;
                x = y;
                y = t;
            end
            e.g  = x;
            e.st = (x == 1) ? 2'd0 : 2'd3;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic recover();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        sb.delete();
        tick();
    endtask

    // Accept a request, wait for result, compare, optionally stall, then consume.
    task automatic run_req(input logic [W-1:0] s, input logic [W-1:0] mm,
                           input int stall, input string name);
        exp_t e;
        int lat;
        int w;
        logic [1:0] st0;
        logic [W-1:0] g0;
        logic sv0;
        w = 0;
        while (!in_ready && w < 5) begin
            tick();
            w++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready: got %b want 1", name, in_ready);
            recover();
            return;
        end
        in_valid = 1'b1;
        seed = s;
        m = mm;
        sb.push_back(model(s, mm));
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat <= 2 * W + 3) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_in_ready: got %b want 0", name, in_ready);
            end
            tick();
            lat++;
        end
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: no res_valid after %0d cycles", name, lat);
            recover();
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (e.st == 2'd1 || e.st == 2'd2) begin
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL %s latency: got %0d want 2", name, lat);
            end
        end else if (lat > 2 * W + 3 || lat < 3) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want 3..%0d", name, lat, 2 * W + 3);
        end
        n_checks++;
        if (status !== e.st) begin
            n_fail++;
            $display("FAIL %s status: got %0d want %0d", name, status, e.st);
        end
        n_checks++;
        if (gcd_out !== e.g) begin
            n_fail++;
            $display("FAIL %s gcd_out: got %0d want %0d", name, gcd_out, e.g);
        end
        n_checks++;
        if (seed_valid !== (e.st == 2'd0)) begin
            n_fail++;
            $display("FAIL %s seed_valid: got %b want %b", name, seed_valid, e.st == 2'd0);
        end
`ifdef SEED_CHECK_STATS_EN
        n_checks++;
        if (cycles !== 16'(lat - 2)) begin
            n_fail++;
            $display("FAIL %s cycles: got %0d want %0d", name, cycles, lat - 2);
        end
`endif
        st0 = status;
        g0 = gcd_out;
        sv0 = seed_valid;
        for (int i = 0; i < stall; i++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || status !== st0 ||
                gcd_out !== g0 || seed_valid !== sv0) begin
                n_fail++;
                $display("FAIL %s stall%0d: rv=%b ir=%b st=%0d g=%0d sv=%b want 1 0 %0d %0d %b",
                         name, i, res_valid, in_ready, status, gcd_out, seed_valid, st0, g0, sv0);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || status !== st0 || gcd_out !== g0) begin
            n_fail++;
            $display("FAIL %s consume: rv=%b ir=%b st=%0d g=%0d want 0 1 %0d %0d",
                     name, res_valid, in_ready, status, gcd_out, st0, g0);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || seed_valid !== 1'b0 ||
            status !== 2'd0 || gcd_out !== '0) begin
            n_fail++;
            $display("FAIL reset: ir=%b rv=%b sv=%b st=%0d g=%0d want 1 0 0 0 0",
                     in_ready, res_valid, seed_valid, status, gcd_out);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_coprime();
        run_req(16'd3, 16'd253, 0, "coprime_3_253");
        run_req(16'd2, 16'd65535, 0, "coprime_2_65535");
        run_req(16'd65534, 16'd65535, 0, "coprime_max");
    endtask

    task automatic test_m_even();
        run_req(16'd3, 16'd6, 0, "m_even_3_6");
    endtask

    task automatic test_range();
        run_req(16'd0, 16'd253, 0, "range_0");
        run_req(16'd253, 16'd253, 0, "range_eq");
        run_req(16'd1, 16'd253, 0, "range_1");
    endtask

    task automatic test_not_coprime();
        run_req(16'd11, 16'd253, 0, "nc_11_253");
        run_req(16'd15, 16'd45, 0, "nc_15_45");
    endtask

    task automatic test_random();
        logic [W-1:0] mm, s;
        for (int i = 0; i < 12; i++) begin
            mm = W'($urandom_range(3, 65535));
            if (i % 4 != 0) mm[0] = 1'b1;
            s = W'($urandom_range(0, 65535)) % mm;
            run_req(s, mm, 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_req(16'd3, 16'd253, 10, "backpressure");
        run_req(16'd5, 16'd77, 0, "back_to_back");
    endtask

    task automatic test_reset_mid_gcd();
        in_valid = 1'b1;
        seed = 16'd3;
        m = 16'd253;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || seed_valid !== 1'b0 ||
            status !== 2'd0 || gcd_out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: ir=%b rv=%b sv=%b st=%0d g=%0d want 1 0 0 0 0",
                     in_ready, res_valid, seed_valid, status, gcd_out);
        end
`ifdef SEED_CHECK_STATS_EN
        n_checks++;
        if (cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset cycles: got %0d want 0", cycles);
        end
`endif
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset no_result: rv=%b want 0", res_valid);
        end
        run_req(16'd3, 16'd253, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_coprime();
        test_m_even();
        test_range();
        test_not_coprime();
        test_random();
        test_back_to_back();
        test_not_coprime();
        test_reset_mid_gcd();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
